bcd_to_binary: RTL



---
 rtl/bcd_to_binary_pkg.sv | 23 ++
 rtl/bcd_to_binary_digit_adjust.sv | 16 +
 rtl/bcd_to_binary.sv | 99 +++++++++
 3 files changed

// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM states,
// digit constants and default sizing.
package bcd_to_binary_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        ADJUST = 3'd2,
        DONE   = 3'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ_THRESHOLD = 4'd8;
    localparam logic [3:0] ADJ_VALUE     = 4'd3;

    localparam int unsigned DEFAULT_DIGITS    = 4;
    localparam int unsigned DEFAULT_BIN_WIDTH = 14;

    function automatic logic digit_valid(input logic [3:0] nibble);
        return nibble <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_binary_digit_adjust.sv
// Single-nibble correction step of reverse double-dabble:
// digits of 8 or more lose 3 after each right shift.
module bcd_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [3:0] o_Nibble
);

    always_comb begin
        o_Nibble = i_Nibble;
        if (i_Nibble >= ADJ_THRESHOLD)
            o_Nibble = i_Nibble - ADJ_VALUE;
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: converts a packed BCD value to binary
// with a start/busy/done handshake, rejecting starts that carry a non-decimal digit.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int unsigned DIGITS    = DEFAULT_DIGITS,
    parameter int unsigned BIN_WIDTH = DEFAULT_BIN_WIDTH
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic [4*DIGITS-1:0]   i_BCD,
    output logic [BIN_WIDTH-1:0]  o_Binary,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(W);

    state_t           state;
    logic [W-1:0]     bcd_r;
    logic [W-1:0]     bin_r;
    logic [W-1:0]     bcd_adj;
    logic [CNT_W-1:0] cnt;
    logic             bcd_valid;

    always_comb begin
        bcd_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!digit_valid(i_BCD[4*i +: 4]))
                bcd_valid = 1'b0;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_Nibble (bcd_r[4*g +: 4]),
            .o_Nibble (bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= IDLE;
            bcd_r    <= '0;
            bin_r    <= '0;
            cnt      <= '0;
            o_Binary <= '0;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
            o_Error  <= 1'b0;
        end else begin
            o_Done  <= 1'b0;
            o_Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        if (bcd_valid) begin
                            bcd_r  <= i_BCD;
                            bin_r  <= '0;
                            cnt    <= '0;
                            o_Busy <= 1'b1;
                            state  <= SHIFT;
                        end else begin
                            o_Error <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Whole working register moves right; BCD LSB feeds binary MSB.
                    {bcd_r, bin_r} <= {1'b0, bcd_r, bin_r[W-1:1]};
                    if (cnt == CNT_W'(W - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= ADJUST;
                    end
                end
                ADJUST: begin
                    bcd_r <= bcd_adj;
                    state <= SHIFT;
                end
                DONE: begin
                    o_Binary <= BIN_WIDTH'(bin_r);
                    o_Done   <= 1'b1;
                    o_Busy   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
